// File: rtl/board_scanner.sv
// Scans a snapshot of an 8x8 board one square per ready/valid beat, flagging legal-move
// destinations and totalling red/white pieces into win flags at the end of each scan.
module board_scanner (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [191:0] serialized_board,
  input  logic [27:0]  legal_move,
  output logic         sq_valid,
  input  logic         sq_ready,
  output logic [5:0]   sq_loc,
  output logic [2:0]   sq_code,
  output logic         sq_legal,
  output logic         busy,
  output logic         done,
  output logic [6:0]   red_count,
  output logic [6:0]   white_count,
  output logic         red_win,
  output logic         white_win
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e         state_q, state_d;
  logic [191:0]   board_q, board_d;
  logic [27:0]    legal_q, legal_d;
  logic [5:0]     idx_q, idx_d;
  logic [6:0]     red_run_q, red_run_d;
  logic [6:0]     white_run_q, white_run_d;
  logic [6:0]     red_count_q, red_count_d;
  logic [6:0]     white_count_q, white_count_d;
  logic           red_win_q, red_win_d;
  logic           white_win_q, white_win_d;

  logic [7:0]     base;
  logic [2:0]     code;
  logic           red_add, white_add;
  logic [6:0]     red_tot, white_tot;
  logic           legal_hit;
  logic           scanning;

  always_comb begin
    base      = {2'b00, idx_q} * 8'd3;
    code      = board_q[base +: 3];
    red_add   = code[2] & code[1];
    white_add = code[2] & ~code[1];
    red_tot   = red_run_q + {6'd0, red_add};
    white_tot = white_run_q + {6'd0, white_add};
    scanning  = (state_q == StScan);
  end

  // Duplicate slots simply OR together into a single hit.
  always_comb begin
    legal_hit = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (legal_q[s*7+6] && (legal_q[s*7 +: 6] == idx_q)) legal_hit = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    legal_d       = legal_q;
    idx_d         = idx_q;
    red_run_d     = red_run_q;
    white_run_d   = white_run_q;
    red_count_d   = red_count_q;
    white_count_d = white_count_q;
    red_win_d     = red_win_q;
    white_win_d   = white_win_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          board_d     = serialized_board;
          legal_d     = legal_move;
          idx_d       = 6'd0;
          red_run_d   = 7'd0;
          white_run_d = 7'd0;
          state_d     = StScan;
        end
      end
      StScan: begin
        if (sq_ready) begin
          red_run_d   = red_tot;
          white_run_d = white_tot;
          if (idx_q == 6'd63) begin
            // Last beat: publish totals, index stays put rather than wrapping.
            red_count_d   = red_tot;
            white_count_d = white_tot;
            red_win_d     = (white_tot == 7'd0) && (red_tot != 7'd0);
            white_win_d   = (red_tot == 7'd0) && (white_tot != 7'd0);
            state_d       = StDone;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      board_q       <= '0;
      legal_q       <= '0;
      idx_q         <= '0;
      red_run_q     <= '0;
      white_run_q   <= '0;
      red_count_q   <= '0;
      white_count_q <= '0;
      red_win_q     <= 1'b0;
      white_win_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      board_q       <= board_d;
      legal_q       <= legal_d;
      idx_q         <= idx_d;
      red_run_q     <= red_run_d;
      white_run_q   <= white_run_d;
      red_count_q   <= red_count_d;
      white_count_q <= white_count_d;
      red_win_q     <= red_win_d;
      white_win_q   <= white_win_d;
    end
  end

  // Descriptor fields read as zero whenever no descriptor is presented.
  always_comb begin
    sq_valid    = scanning;
    busy        = scanning;
    done        = (state_q == StDone);
    sq_loc      = scanning ? idx_q : 6'd0;
    sq_code     = scanning ? code : 3'd0;
    sq_legal    = scanning & legal_hit;
    red_count   = red_count_q;
    white_count = white_count_q;
    red_win     = red_win_q;
    white_win   = white_win_q;
  end

endmodule

// File: doc/board_scanner.md
BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the 8x8 board encoding.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request one full board scan.
REQ-005 The block SHALL have port serialized_board, input, 192 bits: square i occupies bits [i*3+2:i*3], where i = {x[2:0], y[2:0]}. Within each square, bit2 = piece present, bit1 = red, bit0 = king.
REQ-006 The block SHALL have port legal_move, input, 28 bits: four 7-bit slots at [6:0], [13:7], [20:14] and [27:21]; in each slot, bit6 = valid and bits[5:0] = destination square.
REQ-007 The block SHALL have port sq_valid, output, 1 bit: a square descriptor is presented.
REQ-008 The block SHALL have port sq_ready, input, 1 bit: the downstream consumer accepts the descriptor.
REQ-009 The block SHALL have port sq_loc, output, 6 bits: index of the square being presented.
REQ-010 The block SHALL have port sq_code, output, 3 bits: the 3-bit square code from the snapshot.
REQ-011 The block SHALL have port sq_legal, output, 1 bit: the presented square is a legal-move destination.
REQ-012 The block SHALL have port busy, output, 1 bit: a scan is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: a one-cycle pulse at scan completion.
REQ-014 The block SHALL have ports red_count and white_count, outputs, 7 bits each: piece totals from the last completed scan.
REQ-015 The block SHALL have ports red_win and white_win, outputs, 1 bit each: win flags from the last completed scan.

Function
REQ-016 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-017 In IDLE, start=1 at a clock edge SHALL have these effects: snapshot serialized_board and legal_move, set the index to 0, clear the running counters, and go to SCAN.
REQ-018 start SHALL be ignored in SCAN and DONE; no queuing.
REQ-019 sq_valid SHALL be 1 exactly while in SCAN; busy SHALL equal sq_valid.
REQ-020 A transfer SHALL occur at a clock edge where sq_valid=1 and sq_ready=1. On a transfer the index increments, and the running counters add the square: red if code bit2=1 and bit1=1, white if bit2=1 and bit1=0.
REQ-021 While sq_valid=1 and sq_ready=0, sq_loc, sq_code and sq_legal SHALL hold stable.
REQ-022 sq_code SHALL come from the snapshot only; changes on serialized_board during a scan SHALL not affect the scan.
REQ-023 sq_legal SHALL be 1 iff any snapshot slot has bit6=1 and bits[5:0]=sq_loc. Duplicate slots SHALL still give a single 1.
REQ-024 The transfer of index 63 SHALL move the FSM to DONE; the index SHALL not wrap into a second pass.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-026 red_count and white_count SHALL update at the edge entering DONE, with values 0..64, and SHALL hold between scans.
REQ-027 Win flags SHALL update at the same edge as the counts:
- red_win = (white total = 0) and (red total ≠ 0)
- white_win = (red total = 0) and (white total ≠ 0)
- an empty board gives both flags 0.
REQ-028 Latency with sq_ready held at 1: start sampled at edge N gives sq_valid=1 with sq_loc=0 after edge N, and done=1 after edge N+64.
REQ-029 A start that is high in the DONE cycle SHALL be ignored; a new scan needs start=1 in IDLE.

Reset
REQ-030 When rst=1, the block SHALL go to IDLE immediately, asynchronously, including mid-scan.
REQ-031 On reset, all outputs SHALL be 0: sq_valid, sq_loc, sq_code, sq_legal, busy, done, counts and win flags.
REQ-032 On reset, the snapshot registers and running counters SHALL be cleared.

Verification
REQ-033 Scenario 1: board with square 9=3'b100, 29=3'b101, 50=3'b110, 54=3'b111, other squares 0; sq_ready held at 1; start pulse -> 64 beats with sq_loc 0..63; sq_code = 3'b110 at beat 50; done occurs 64 cycles after the first beat; red_count=2, white_count=2; both win flags 0.
REQ-034 Scenario 2: same board; sq_ready=0 for 5 cycles while sq_loc=10 -> sq_loc, sq_code and sq_legal hold; scan completes after 69 valid cycles.
REQ-035 Scenario 3: legal_move = {14'b0, 7'b1_010_110, 7'b1_000_010} -> sq_legal=1 only at sq_loc=2 and sq_loc=22.
REQ-036 Scenario 4: board with only squares 50 and 54 occupied -> red_count=2, white_count=0, red_win=1, white_win=0; all-empty board -> both win flags 0.
REQ-037 Scenario 5: rst=1 while sq_loc=30 -> all outputs 0 immediately; after rst=0, start gives a scan that begins at sq_loc=0.
REQ-038 Scenario 6: serialized_board changed to all zeros after beat 5 -> remaining beats use the original snapshot and counts are unchanged from Scenario 1.
